// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one combinational FloatingPointAdder
// among NUM_REQ valid/ready requesters, with a tagged response channel.

module FloatingPointAdder #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  localparam int W = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);
  localparam int M  = MANTISSA_SIZE;
  localparam int E  = EXPONENT_SIZE;
  localparam int MW = M + 5;
  localparam logic [E:0] ONE  = (E+1)'(1);
  localparam logic [E:0] EMAX = {1'b0, {E{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  logic          w_swap;
  logic [W-1:0]  w_l;
  logic [W-1:0]  w_s;
  logic          w_sl;
  logic          w_ss;
  logic [E:0]    w_el;
  logic [E:0]    w_es;
  logic [E:0]    w_d;
  logic [MW-1:0] w_ml;
  logic [MW-1:0] w_ms;
  logic [MW-1:0] w_mask;
  logic [MW-1:0] w_al;
  logic [MW-1:0] w_sum;
  logic [MW-2:0] w_n;
  logic [E:0]    w_e;
  logic [E:0]    w_ef;
  int            w_lz;
  int            w_sh;
  logic          w_found;
  logic          w_up;
  logic [M+1:0]  w_mr;
  logic [M-1:0]  w_frac;
  logic          w_hid;
  logic          w_a_max;
  logic          w_b_max;
  logic          w_nan;

  assign w_swap = i_b[W-2:0] > i_a[W-2:0];
  assign w_l    = w_swap ? i_b : i_a;
  assign w_s    = w_swap ? i_a : i_b;
  assign w_sl   = w_l[W-1];
  assign w_ss   = w_s[W-1];

  // Subnormals use an effective exponent of 1 and no hidden bit
  assign w_el = (w_l[W-2:M] == '0) ? ONE : {1'b0, w_l[W-2:M]};
  assign w_es = (w_s[W-2:M] == '0) ? ONE : {1'b0, w_s[W-2:M]};
  assign w_ml = {1'b0, |w_l[W-2:M], w_l[M-1:0], 3'b000};
  assign w_ms = {1'b0, |w_s[W-2:M], w_s[M-1:0], 3'b000};

  assign w_d    = w_el - w_es;
  assign w_mask = ~({MW{1'b1}} << w_d);
  assign w_al   = (w_ms >> w_d) | {{(MW-1){1'b0}}, |(w_ms & w_mask)};
  assign w_sum  = (w_sl == w_ss) ? w_ml + w_al : w_ml - w_al;

  always_comb begin
    w_lz    = 0;
    w_found = 1'b0;
    for (int i = MW - 2; i >= 0; i--) begin
      if (!w_found) begin
        if (w_sum[i]) w_found = 1'b1;
        else          w_lz    = w_lz + 1;
      end
    end
  end

  always_comb begin
    w_sh = 0;
    w_n  = w_sum[MW-2:0];
    w_e  = w_el;
    if (w_sum[MW-1]) begin
      w_n = {w_sum[MW-1:2], w_sum[1] | w_sum[0]};
      w_e = w_el + ONE;
    end else begin
      w_sh = (w_lz < int'(w_el) - 1) ? w_lz : int'(w_el) - 1;
      w_n  = w_sum[MW-2:0] << w_sh;
      w_e  = w_el - (E+1)'(w_sh);
    end
  end

  // Round to nearest, ties to even, on guard/round/sticky
  assign w_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
  assign w_mr = {1'b0, w_n[MW-2:3]} + {{(M+1){1'b0}}, w_up};
  assign w_hid = w_mr[M+1] | w_mr[M];

  always_comb begin
    w_ef   = w_e;
    w_frac = w_mr[M-1:0];
    if (w_mr[M+1]) begin
      w_ef   = w_e + ONE;
      w_frac = w_mr[M:1];
    end
  end

  assign w_a_max = &i_a[W-2:M];
  assign w_b_max = &i_b[W-2:M];
  assign w_nan   = (w_a_max & (|i_a[M-1:0])) | (w_b_max & (|i_b[M-1:0])) |
                   (w_a_max & w_b_max & (i_a[W-1] != i_b[W-1]));

  always_comb begin
    o_sum = {w_sl, w_hid ? w_ef[E-1:0] : {E{1'b0}}, w_frac};
    if (w_a_max | w_b_max)
      o_sum = w_nan ? QNAN : {w_sl, {E{1'b1}}, {M{1'b0}}};
    else if (w_sum == '0)
      o_sum = {w_sl & w_ss, {(W-1){1'b0}}};
    else if (w_ef >= EMAX)
      o_sum = {w_sl, {E{1'b1}}, {M{1'b0}}};
  end
endmodule

module fp_adder_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  localparam int W     = 1 + EXPONENT_SIZE + MANTISSA_SIZE,
  localparam int TAG_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [W-1:0]         resp_result,
  output logic [TAG_W-1:0]     resp_tag,
  output logic                 busy
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_last;
  logic             r_resp_valid;
  logic [W-1:0]     r_result;
  logic [TAG_W-1:0] r_resp_tag;
  logic [TAG_W-1:0] w_grant;
  logic [TAG_W-1:0] w_idx;
  logic             w_any;
  logic             w_hs;
  logic [W-1:0]     w_sum;

  FloatingPointAdder #(
    .MANTISSA_SIZE(MANTISSA_SIZE),
    .EXPONENT_SIZE(EXPONENT_SIZE)
  ) u_add (
    .i_a  (r_op_a),
    .i_b  (r_op_b),
    .o_sum(w_sum)
  );

  // Scan farthest-first so the nearest valid index after r_last wins
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = TAG_W'((int'(r_last) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_any && !rst)
      req_ready[w_grant] = 1'b1;
  end

  assign w_hs = |(req_valid & req_ready);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_hs) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_tag        <= '0;
      r_last       <= TAG_W'(NUM_REQ - 1);
      r_resp_valid <= 1'b0;
      r_result     <= '0;
      r_resp_tag   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_hs) begin
        r_op_a <= req_a[int'(w_grant)*W +: W];
        r_op_b <= req_b[int'(w_grant)*W +: W];
        r_tag  <= w_grant;
        r_last <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_result     <= w_sum;
        r_resp_tag   <= r_tag;
        r_resp_valid <= 1'b1;
      end
      if (r_state == S_RESP && resp_ready)
        r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_result = r_result;
  assign resp_tag    = r_resp_tag;
  assign busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: vector table plus
// round-robin, backpressure, priority, async-reset and idle sequences.

module tb_fp_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_result;
  logic [TW-1:0]  resp_tag;
  logic           busy;

  fp_adder_arbiter #(
    .NUM_REQ(N),
    .MANTISSA_SIZE(23),
    .EXPONENT_SIZE(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] rr_a[4];
  logic [31:0] rr_b[4];
  logic [31:0] rr_s[4];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_multi = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if ($countones(req_ready) > 1) n_multi++;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_timeout: got no resp_valid expected 1");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_op(input int i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] s);
    @(negedge clk);
    set_op(i, a, b);
    req_valid = N'(1) << i;
    #1 chk("op_ready", 32'(req_ready), 32'(N'(1) << i));
    @(negedge clk);
    req_valid = '0;
    chk("op_exec", {busy, resp_valid}, 2'b10);
    @(negedge clk);
    chk("op_valid", resp_valid, 1);
    chk("op_result", resp_result, s);
    chk("op_tag", resp_tag, 32'(i));
    @(negedge clk);
    chk("op_done", {busy, resp_valid}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int prev;
    int bad;

    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1] = '{1, 32'h40A00000, 32'hC0400000, 32'h40000000};
    vecs[2] = '{2, 32'h3FC00000, 32'h40200000, 32'h40800000};
    vecs[3] = '{3, 32'h3F000000, 32'h3E800000, 32'h3F400000};
    vecs[4] = '{0, 32'h40400000, 32'hC0400000, 32'h00000000};
    vecs[5] = '{1, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    vecs[6] = '{2, 32'h3F800000, 32'h33800000, 32'h3F800000};
    vecs[7] = '{3, 32'h3F800001, 32'h33800000, 32'h3F800002};

    rr_a = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h3F000000};
    rr_b = '{32'h3F800000, 32'h40000000, 32'h40200000, 32'h3E800000};
    rr_s = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3F400000};

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_ctrl", {resp_valid, busy, req_ready}, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_tag", resp_tag, 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      do_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sum);

    // Round robin with everybody valid
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_op(i, rr_a[i], rr_b[i]);
    req_valid = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_resp(ok);
      if (!ok) break;
      if (k == 4) req_valid = '0;
      chk("rr_tag", resp_tag, 32'(k % N));
      chk("rr_result", resp_result, rr_s[k % N]);
      if (k > 0) chk("rr_interval", cyc - prev, 3);
      prev = cyc;
    end
    req_valid = '0;
    chk("rr_onehot", n_multi, 0);
    repeat (3) @(negedge clk);

    // Backpressure on requester 2
    resp_ready = 1'b0;
    set_op(2, 32'h3FC00000, 32'h40200000);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b1011;
    wait_resp(ok);
    for (int c = 0; c < 5; c++) begin
      chk("bp_result", resp_result, 32'h40800000);
      chk("bp_ctrl", {resp_valid, busy, req_ready, resp_tag},
          {1'b1, 1'b1, 4'b0000, 2'd2});
      @(negedge clk);
    end
    resp_ready = 1'b1;
    req_valid  = '0;
    #1 chk("bp_last", {resp_valid, resp_tag}, {1'b1, 2'd2});
    @(negedge clk);
    chk("bp_release", {busy, resp_valid}, 2'b00);

    // Requester 3 served, then 0 and 3 together: 0 wins
    do_op(3, 32'h3F800000, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    set_op(0, 32'h3F000000, 32'h3E800000);
    set_op(3, 32'h3F800000, 32'h40000000);
    req_valid = 4'b1001;
    #1 chk("prio_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    chk("prio_tag", resp_tag, 0);
    chk("prio_result", resp_result, 32'h3F400000);
    @(negedge clk);

    // Async reset while in EXEC
    set_op(1, 32'h40A00000, 32'h40A00000);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("arst_pre", {busy, resp_valid}, 2'b10);
    #2 rst = 1'b1;
    #1 chk("arst_ctrl", {resp_valid, busy, req_ready}, 0);
    chk("arst_result", resp_result, 0);
    chk("arst_tag", resp_tag, 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) bad++;
    end
    chk("arst_noresp", bad, 0);
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(3, 32'h3F000000, 32'h3E800000);
    req_valid = 4'b1001;
    #1 chk("arst_prio", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    chk("arst_tag2", resp_tag, 0);
    chk("arst_result2", resp_result, 32'h40400000);

    // Idle hygiene
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || resp_valid || (|req_ready)) bad++;
    end
    chk("idle", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
